// File: rtl/por_ee_rd_seq_if.sv
// Bundle between the power-on config FSM / EE array and the read sequencer.
//   Config side : por_vs_en, por_rd_en, por_ee_addr (to sequencer)
//                 por_ee_data_e2l, rd_busy, rd_done, rd_abort (from sequencer)
//   Array side  : ee_dout (to sequencer); ee_vs, ee_se, ee_addr (from sequencer)
// Modport slave is taken by the sequencer; master by whatever drives it.
interface por_ee_rd_seq_if;
    logic        por_vs_en;
    logic        por_rd_en;
    logic [15:0] por_ee_addr;
    logic [7:0]  ee_dout;
    logic        ee_vs;
    logic        ee_se;
    logic [15:0] ee_addr;
    logic [31:0] por_ee_data_e2l;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_abort;

    modport slave (
        input  por_vs_en, por_rd_en, por_ee_addr, ee_dout,
        output ee_vs, ee_se, ee_addr, por_ee_data_e2l, rd_busy, rd_done, rd_abort
    );

    modport master (
        output por_vs_en, por_rd_en, por_ee_addr, ee_dout,
        input  ee_vs, ee_se, ee_addr, por_ee_data_e2l, rd_busy, rd_done, rd_abort
    );
endinterface

// File: rtl/por_ee_rd_seq.sv
// EEPROM read sequencer. On a rising edge of por_rd_en (with por_vs_en high) it
// reads the four bytes of the addressed word from the 8-bit array port, pulsing
// ee_se for SENSE_CYC cycles per byte, and publishes the little-endian word on
// por_ee_data_e2l together with a one-cycle rd_done.
// Ports:
//   timer_clk  - clock
//   por_rst_n  - asynchronous active-low reset
//   bus        - por_ee_rd_seq_if.slave (config-side request/result, array-side
//                sense controls and data)
// SENSE_CYC legal range is 1..7 (cnt is 3 bits wide).
module por_ee_rd_seq #(
    parameter int unsigned SENSE_CYC = 2,
    parameter logic [31:0] RST_DATA  = 32'h0000_0000
) (
    input logic            timer_clk,
    input logic            por_rst_n,
    por_ee_rd_seq_if.slave bus
);

    localparam logic [2:0] CntLast = 3'(SENSE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSense,
        StLatch,
        StWaitLow
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] byte_buf_q, byte_buf_d;
    logic [31:0] data_q, data_d;
    logic [15:0] ee_addr_q, ee_addr_d;
    logic        ee_se_q, ee_se_d;
    logic        rd_busy_q, rd_busy_d;
    logic        rd_done_q, rd_done_d;
    logic        rd_abort_q, rd_abort_d;
    logic        ee_vs_q;
    logic        rd_en_q;

    logic start;
    logic abort;

    assign start = bus.por_rd_en & ~rd_en_q & bus.por_vs_en;
    assign abort = ~bus.por_rd_en | ~bus.por_vs_en;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;
        byte_buf_d = byte_buf_q;
        data_d     = data_q;
        ee_addr_d  = ee_addr_q;
        ee_se_d    = ee_se_q;
        rd_busy_d  = rd_busy_q;
        rd_done_d  = 1'b0;
        rd_abort_d = rd_abort_q;

        // Abort wins over everything in the active states, including the
        // final latch, so a half-read word never reaches por_ee_data_e2l.
        if ((state_q inside {StSetup, StSense, StLatch}) && abort) begin
            state_d    = StIdle;
            ee_se_d    = 1'b0;
            rd_busy_d  = 1'b0;
            rd_abort_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ee_addr_d  = {bus.por_ee_addr[15:2], 2'b00};
                        byte_idx_d = 2'd0;
                        rd_busy_d  = 1'b1;
                        rd_abort_d = 1'b0;
                        state_d    = StSetup;
                    end
                end
                StSetup: begin
                    ee_se_d = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = StSense;
                end
                StSense: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CntLast) begin
                        ee_se_d = 1'b0;
                        state_d = StLatch;
                    end
                end
                StLatch: begin
                    if (byte_idx_q != 2'd3) begin
                        case (byte_idx_q)
                            2'd0:    byte_buf_d[7:0]   = bus.ee_dout;
                            2'd1:    byte_buf_d[15:8]  = bus.ee_dout;
                            default: byte_buf_d[23:16] = bus.ee_dout;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                        // Upper address bits still hold the captured word base.
                        ee_addr_d  = {ee_addr_q[15:2], byte_idx_q + 2'd1};
                        ee_se_d    = 1'b1;
                        cnt_d      = 3'd0;
                        state_d    = StSense;
                    end else begin
                        data_d    = {bus.ee_dout, byte_buf_q};
                        rd_done_d = 1'b1;
                        rd_busy_d = 1'b0;
                        state_d   = StWaitLow;
                    end
                end
                StWaitLow: begin
                    if (!bus.por_rd_en) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge timer_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            cnt_q      <= 3'd0;
            byte_buf_q <= 24'd0;
            data_q     <= RST_DATA;
            ee_addr_q  <= 16'h0000;
            ee_se_q    <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_abort_q <= 1'b0;
            ee_vs_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            byte_buf_q <= byte_buf_d;
            data_q     <= data_d;
            ee_addr_q  <= ee_addr_d;
            ee_se_q    <= ee_se_d;
            rd_busy_q  <= rd_busy_d;
            rd_done_q  <= rd_done_d;
            rd_abort_q <= rd_abort_d;
            ee_vs_q    <= bus.por_vs_en;
            rd_en_q    <= bus.por_rd_en;
        end
    end

    assign bus.ee_vs           = ee_vs_q;
    assign bus.ee_se           = ee_se_q;
    assign bus.ee_addr         = ee_addr_q;
    assign bus.por_ee_data_e2l = data_q;
    assign bus.rd_busy         = rd_busy_q;
    assign bus.rd_done         = rd_done_q;
    assign bus.rd_abort        = rd_abort_q;

endmodule

// File: tb/tb_por_ee_rd_seq.sv
// Bench for por_ee_rd_seq: directed scenarios, a schedule-based reference model
// checked every cycle, and literal expectations for each scenario.
module tb_por_ee_rd_seq;

    localparam int          S        = 2;
    localparam int          TOTAL    = 1 + 4 * (S + 1);
    localparam logic [31:0] RST_DATA = 32'h5A5A_C3C3;

    logic timer_clk;
    logic por_rst_n;

    por_ee_rd_seq_if bus ();

    por_ee_rd_seq #(
        .SENSE_CYC (S),
        .RST_DATA  (RST_DATA)
    ) dut (
        .timer_clk (timer_clk),
        .por_rst_n (por_rst_n),
        .bus       (bus)
    );

    initial begin
        timer_clk = 1'b0;
        forever #5 timer_clk = ~timer_clk;
    end

    // Array model: combinational read of a byte memory.
    logic [7:0] mem [0:65535];
    assign bus.ee_dout = mem[bus.ee_addr];

    int n_checks;
    int n_pass;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a read is a fixed schedule counted in edges from the
    // start edge (m_e = 0). Byte b occupies edges 1+b*(S+1) .. (b+1)*(S+1),
    // sense enable for the first S of them; the word appears at edge TOTAL.
    bit          m_active, m_wait, m_prev_rd, m_vs, m_done, m_abort;
    int          m_e;
    logic [15:0] m_base, m_addr;
    logic [31:0] m_word, m_data;

    function automatic logic [15:0] byte_of(input int e);
        int b;
        b = (e - 1) / (S + 1);
        if (b > 3) b = 3;
        return 16'(b);
    endfunction

    always @(posedge timer_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            m_active <= 0; m_wait <= 0; m_prev_rd <= 0; m_vs <= 0; m_done <= 0;
            m_abort <= 0; m_e <= 0; m_base <= '0; m_addr <= '0; m_word <= '0;
            m_data <= RST_DATA;
        end else begin
            m_done <= 0;
            if (m_active) begin
                if (!bus.por_rd_en || !bus.por_vs_en) begin
                    m_active <= 0;
                    m_abort  <= 1;
                end else begin
                    m_e <= m_e + 1;
                    if (m_e + 1 == TOTAL) begin
                        m_active <= 0;
                        m_done   <= 1;
                        m_data   <= m_word;
                        m_wait   <= 1;
                    end else begin
                        m_addr <= m_base + byte_of(m_e + 1);
                    end
                end
            end else if (m_wait) begin
                if (!bus.por_rd_en) m_wait <= 0;
            end else if (bus.por_rd_en && !m_prev_rd && bus.por_vs_en) begin
                m_active <= 1;
                m_e      <= 0;
                m_abort  <= 0;
                m_base   <= {bus.por_ee_addr[15:2], 2'b00};
                m_addr   <= {bus.por_ee_addr[15:2], 2'b00};
                m_word   <= {mem[{bus.por_ee_addr[15:2], 2'b11}], mem[{bus.por_ee_addr[15:2], 2'b10}],
                             mem[{bus.por_ee_addr[15:2], 2'b01}], mem[{bus.por_ee_addr[15:2], 2'b00}]};
            end
            m_prev_rd <= bus.por_rd_en;
            m_vs      <= bus.por_vs_en;
        end
    end

    function automatic bit exp_se();
        return m_active && (m_e >= 1) && (((m_e - 1) % (S + 1)) < S);
    endfunction

    always @(negedge timer_clk) begin
        if (chk_en) begin
            check("ee_vs",    32'(bus.ee_vs),    32'(m_vs));
            check("ee_se",    32'(bus.ee_se),    32'(exp_se()));
            check("ee_addr",  32'(bus.ee_addr),  32'(m_addr));
            check("data",     bus.por_ee_data_e2l, m_data);
            check("rd_busy",  32'(bus.rd_busy),  32'(m_active));
            check("rd_done",  32'(bus.rd_done),  32'(m_done));
            check("rd_abort", 32'(bus.rd_abort), 32'(m_abort));
        end
    end

    // Per-cycle log of the last run_read, indexed by edges since start.
    logic [15:0] addr_log  [64];
    logic        se_log    [64];
    logic        busy_log  [64];
    logic        abort_log [64];

    // Raise por_rd_en (and por_vs_en) so the next edge is edge 0; keep rd_en for
    // 'hold' edges and vs_en for 'vs_hold' edges; observe 'total' edges.
    task automatic run_read(input logic [15:0] addr, input int hold, input int vs_hold,
                            input int total, output int lat, output int n_done,
                            output int n_se);
        lat = -1; n_done = 0; n_se = 0;
        @(negedge timer_clk);
        bus.por_ee_addr = addr;
        bus.por_vs_en   = 1'b1;
        bus.por_rd_en   = 1'b1;
        for (int i = 0; i < total; i++) begin
            @(negedge timer_clk);
            if (bus.rd_done) begin n_done++; lat = i; end
            if (bus.ee_se) n_se++;
            if (i < 64) begin
                addr_log[i] = bus.ee_addr; se_log[i] = bus.ee_se;
                busy_log[i] = bus.rd_busy; abort_log[i] = bus.rd_abort;
            end
            if (i == hold - 1)    bus.por_rd_en = 1'b0;
            if (i == vs_hold - 1) bus.por_vs_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    int lat, nd, nse, busy_seen;

    initial begin
        n_checks = 0; n_pass = 0; chk_en = 0;
        por_rst_n = 1'b1;
        bus.por_vs_en = 1'b0; bus.por_rd_en = 1'b0; bus.por_ee_addr = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5C;
        end
        mem[16'hFFF4] = 8'h11; mem[16'hFFF5] = 8'h15; mem[16'hFFF6] = 8'h11; mem[16'hFFF7] = 8'h31;
        mem[16'hFFF8] = 8'hAA; mem[16'hFFF9] = 8'hBB; mem[16'hFFFA] = 8'hCC; mem[16'hFFFB] = 8'hDD;
        #1 por_rst_n = 1'b0;
        repeat (3) @(negedge timer_clk);
        chk_en = 1;
        check("rst_data", bus.por_ee_data_e2l, RST_DATA);
        check("rst_busy", 32'(bus.rd_busy), 32'd0);
        check("rst_addr", 32'(bus.ee_addr), 32'd0);
        por_rst_n = 1'b1;
        repeat (2) @(negedge timer_clk);

        // Nominal read
        run_read(16'hFFF4, 17, 99, 20, lat, nd, nse);
        check("nom_lat", lat, 13);
        check("nom_ndone", nd, 1);
        check("nom_nse", nse, 8);
        check("nom_data", bus.por_ee_data_e2l, 32'h3111_1511);
        check("nom_addr0", 32'(addr_log[1]), 32'hFFF4);
        check("nom_addr1", 32'(addr_log[4]), 32'hFFF5);
        check("nom_addr2", 32'(addr_log[7]), 32'hFFF6);
        check("nom_addr3", 32'(addr_log[10]), 32'hFFF7);

        // Address masking
        run_read(16'hFFFB, 17, 99, 20, lat, nd, nse);
        check("mask_addr0", 32'(addr_log[0]), 32'hFFF8);
        check("mask_data", bus.por_ee_data_e2l, 32'hDDCC_BBAA);

        // Abort by dropping rd_en 6 cycles after start
        run_read(16'h1230, 6, 99, 12, lat, nd, nse);
        check("ab_busy_before", 32'(busy_log[5]), 32'd1);
        check("ab_flag", 32'(abort_log[6]), 32'd1);
        check("ab_se", 32'(se_log[6]), 32'd0);
        check("ab_busy", 32'(busy_log[6]), 32'd0);
        check("ab_ndone", nd, 0);
        check("ab_data", bus.por_ee_data_e2l, 32'hDDCC_BBAA);

        // Following full read clears rd_abort
        run_read(16'h1230, 17, 99, 20, lat, nd, nse);
        check("clr_abort", 32'(abort_log[0]), 32'd0);
        check("clr_ndone", nd, 1);
        check("clr_data", bus.por_ee_data_e2l, 32'h7D7C_7F7E);

        // rd_en pulse with vs_en low is ignored
        @(negedge timer_clk);
        bus.por_vs_en = 1'b0; bus.por_rd_en = 1'b1;
        nse = 0; busy_seen = 0;
        repeat (6) begin
            @(negedge timer_clk);
            if (bus.ee_se) nse++;
            if (bus.rd_busy) busy_seen++;
        end
        bus.por_rd_en = 1'b0;
        check("gate_se", nse, 0);
        check("gate_busy", busy_seen, 0);
        check("gate_abort", 32'(bus.rd_abort), 32'd0);

        // vs_en dropped mid-SENSE of byte 0
        run_read(16'h2468, 10, 3, 14, lat, nd, nse);
        check("vs_se_before", 32'(se_log[2]), 32'd1);
        check("vs_abort", 32'(abort_log[3]), 32'd1);
        check("vs_se", 32'(se_log[3]), 32'd0);
        check("vs_ndone", nd, 0);

        // Held request gives one read; re-toggle gives another
        run_read(16'h0100, 40, 99, 45, lat, nd, nse);
        check("held_ndone", nd, 1);
        check("held_lat", lat, 13);
        check("held_data", bus.por_ee_data_e2l, 32'h5E5F_5C5D);
        run_read(16'hFFF4, 17, 99, 20, lat, nd, nse);
        check("held2_ndone", nd, 1);
        check("held2_data", bus.por_ee_data_e2l, 32'h3111_1511);

        // Reset during byte 2
        run_read(16'hFFF8, 17, 99, 8, lat, nd, nse);
        #2;
        por_rst_n = 1'b0;
        bus.por_rd_en = 1'b0;
        #1;
        check("mr_vs", 32'(bus.ee_vs), 32'd0);
        check("mr_se", 32'(bus.ee_se), 32'd0);
        check("mr_addr", 32'(bus.ee_addr), 32'd0);
        check("mr_data", bus.por_ee_data_e2l, RST_DATA);
        check("mr_busy", 32'(bus.rd_busy), 32'd0);
        check("mr_done", 32'(bus.rd_done), 32'd0);
        check("mr_abort", 32'(bus.rd_abort), 32'd0);
        @(negedge timer_clk);
        #2 por_rst_n = 1'b1;
        run_read(16'hFFF4, 17, 99, 20, lat, nd, nse);
        check("post_rst_ndone", nd, 1);
        check("post_rst_data", bus.por_ee_data_e2l, 32'h3111_1511);

        repeat (2) @(negedge timer_clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/por_ee_rd_seq.md
Name: por_ee_rd_seq

Overview:
- EEPROM read sequencer between the power-on config state machine and the EE array sense path.
- On each por_rd_en rising edge it captures the word address and runs four byte reads against the 8-bit array data port, with a sense-amp enable for each.
- It assembles the four bytes into a 32-bit word and presents it on por_ee_data_e2l before the config machine samples it.
- The full read completes within 13 timer_clk cycles at default parameters, inside the 17-cycle por_rd_en window.

Parameters:
- SENSE_CYC, 2: timer_clk cycles ee_se is held high per byte. Legal range is 1..7.
- RST_DATA, 32'h0000_0000: reset value of por_ee_data_e2l.

Ports:
- timer_clk  in  1  block clock.
- por_rst_n  in  1  reset; asynchronous, active-low.
- por_vs_en  in  1  read-voltage enable from the config FSM.
- por_rd_en  in  1  read request from the config FSM; level held high for the read window.
- por_ee_addr  in  16  byte address of the word; bits [1:0] are ignored.
- ee_dout  in  8  array sense data, valid while ee_se is high.
- ee_vs  out  1  registered copy of por_vs_en, driven to the array.
- ee_se  out  1  sense-amp enable.
- ee_addr  out  16  array byte address.
- por_ee_data_e2l  out  32  assembled read word.
- rd_busy  out  1  high while the sequence is active.
- rd_done  out  1  one-cycle pulse when a word completes.
- rd_abort  out  1  sticky flag: the last read was aborted.

Behaviour:
- Reset and clocking:
  - Reset is por_rst_n, asynchronous, active-low; the clock is timer_clk. Every flop is on timer_clk.
  - Reset values: ee_vs=0, ee_se=0, ee_addr=16'h0000, por_ee_data_e2l=RST_DATA, rd_busy=0, rd_done=0, rd_abort=0, state=IDLE, byte_idx=0, cnt=0, rd_en_d=0.
- Internal registers:
  - ee_vs <= por_vs_en every cycle.
  - rd_en_d <= por_rd_en every cycle.
  - start = por_rd_en & ~rd_en_d & por_vs_en.
- IDLE:
  - On start: capture base = por_ee_addr[15:2]; set ee_addr <= {por_ee_addr[15:2], 2'b00}, byte_idx <= 0, rd_busy <= 1, rd_abort <= 0; go to SETUP.
  - A rising edge of por_rd_en while por_vs_en=0 is ignored and leaves rd_abort unchanged.
- SETUP: one address-settle cycle, then ee_se <= 1, cnt <= 0; go to SENSE.
- SENSE:
  - cnt increments each cycle.
  - When cnt == SENSE_CYC-1: ee_se <= 0; go to LATCH.
- LATCH:
  - Byte assembly is little-endian: byte_idx 0 goes to bits [7:0], byte_idx 3 to bits [31:24]. Bytes 0-2 are written into a 24-bit buffer.
  - If byte_idx < 3: write ee_dout into the buffer slot; byte_idx++; ee_addr <= {base, byte_idx+1}; ee_se <= 1, cnt <= 0; go to SENSE. No SETUP for bytes 1-3; the address settles during the first sense cycle.
  - If byte_idx == 3: por_ee_data_e2l <= {ee_dout, buf[23:0]}; rd_done <= 1 for one cycle; rd_busy <= 0; go to WAIT_LOW.
- WAIT_LOW: stay until por_rd_en == 0, then go to IDLE. A new start is accepted only from IDLE.
- Latency: start edge to rd_done is 1 + 4*(SENSE_CYC+1) cycles, i.e. 13 at default. por_ee_data_e2l updates on the same edge rd_done rises and is then stable.
- Abort: por_rd_en==0 or por_vs_en==0 during SETUP, SENSE or LATCH causes:
  - state <= IDLE, ee_se <= 0, rd_busy <= 0, rd_abort <= 1;
  - por_ee_data_e2l is not modified and rd_done does not pulse.
  - Abort has priority over the LATCH completion in the same cycle.
  - rd_abort stays set until the next accepted start.
- Output properties:
  - ee_se is never high outside SENSE.
  - ee_addr holds its last value while idle.
  - Partial buffer contents are never visible on por_ee_data_e2l.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

Test Plan:
- Nominal read: por_vs_en=1; por_ee_addr=16'hFFF4; por_rd_en high for 17 cycles; array returns 11,15,11,31 for addresses FFF4..FFF7.
  - Expect ee_addr sequence FFF4, FFF5, FFF6, FFF7; ee_se high for 2 cycles per byte.
  - Expect rd_done 13 cycles after the edge and por_ee_data_e2l=32'h3111_1511.
- Address masking: por_ee_addr=16'hFFFB with byte data AA,BB,CC,DD.
  - Expect ee_addr to start at FFF8 and por_ee_data_e2l=32'hDDCC_BBAA.
- Abort on rd_en: drop por_rd_en 6 cycles after start.
  - Expect rd_abort=1, no rd_done, ee_se=0 on the next cycle, por_ee_data_e2l unchanged.
  - A following full read clears rd_abort and updates the data.
- vs_en gating: pulse por_rd_en with por_vs_en=0.
  - Expect no ee_se activity and rd_busy=0.
  - Drop por_vs_en mid-SENSE: expect abort as in the previous scenario.
- Held request: keep por_rd_en high for 40 cycles.
  - Expect exactly one read and one rd_done.
  - Toggle por_rd_en low then high: expect a second read.
- Reset mid-read: assert por_rst_n low during byte 2.
  - Expect every output at its reset value, including por_ee_data_e2l=RST_DATA.
  - After release, a new read completes normally.
